// File: rtl/reset_seq_pkg.sv
// Shared types and sizing helpers for the staggered reset sequencer.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    HOLD     = 2'd0,
    RELEASE  = 2'd1,
    RUN      = 2'd2,
    MAN_WAIT = 2'd3
  } state_t;

  // Bits needed to hold values 0..max_val-1, never less than one bit.
  function automatic int unsigned width_of(input int unsigned max_val);
    int unsigned w;
    w = $clog2(max_val);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchroniser plus debouncer for the raw push-button input.
// rise is asserted during the cycle whose closing edge flips level 0->1,
// so a registered consumer reacts on the same edge that level changes.
module btn_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic in,
  output logic level,
  output logic rise
);
  import reset_seq_pkg::*;

  localparam int DB_W = width_of(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] sync;
  logic [DB_W-1:0]        db_cnt;
  logic                   man_s;
  logic                   mismatch;
  logic                   at_limit;

  assign man_s    = sync[SYNC_STAGES-1];
  assign mismatch = (man_s != level);
  assign at_limit = (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1));
  assign rise     = mismatch & at_limit & ~level;

  // Shift the asynchronous button into the clk domain.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], in};
    end
  end

  // Count consecutive disagreeing cycles; flip level once the run is long enough.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      level  <= 1'b0;
      db_cnt <= '0;
    end else if (!mismatch) begin
      db_cnt <= '0;
    end else if (at_limit) begin
      level  <= ~level;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + DB_W'(1);
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Multi-domain reset sequencer: holds all reset outputs, then releases them
// one at a time in index order. A debounced button press parks the outputs
// asserted until the button is let go; a software request restarts at once.
//
// state    | meaning
// HOLD     | all outputs asserted, counting the initial hold time
// RELEASE  | releasing one channel every stagger interval
// RUN      | every channel released, sequence idle
// MAN_WAIT | button pressed, all asserted until debounced release
module reset_sequencer #(
  parameter int NUM_CH          = 3,
  parameter int HOLD_CYCLES     = 4,
  parameter int STAGGER_CYCLES  = 2,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int SYNC_STAGES     = 2
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              manual,
  input  logic              sw_req,
  output logic [NUM_CH-1:0] rst_out,
  output logic              all_released,
  output logic              busy
);
  import reset_seq_pkg::*;

  localparam int CNT_W = width_of((HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES);
  localparam int IDX_W = width_of(NUM_CH + 1);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   idx_nxt;
  logic [NUM_CH-1:0]  rst_nxt;
  logic               db_level;
  logic               db_rise;

  btn_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn (
    .clk   (clk),
    .n_rst (n_rst),
    .in    (manual),
    .level (db_level),
    .rise  (db_rise)
  );

  // Next-state, counters and next reset vector; button press outranks sw_req.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    rst_nxt   = rst_out;

    if (db_rise) begin
      rst_nxt   = '1;
      state_nxt = MAN_WAIT;
      cnt_nxt   = '0;
      idx_nxt   = '0;
    end else if (sw_req && (state != MAN_WAIT)) begin
      rst_nxt   = '1;
      state_nxt = HOLD;
      cnt_nxt   = '0;
      idx_nxt   = '0;
    end else begin
      case (state)
        HOLD: begin
          rst_nxt = '1;
          if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
            rst_nxt[0] = 1'b0;
            cnt_nxt    = '0;
            idx_nxt    = IDX_W'(1);
            state_nxt  = (NUM_CH == 1) ? RUN : RELEASE;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        RELEASE: begin
          if (cnt == CNT_W'(STAGGER_CYCLES - 1)) begin
            for (int i = 0; i < NUM_CH; i++) begin
              if (idx == IDX_W'(i)) rst_nxt[i] = 1'b0;
            end
            idx_nxt = idx + IDX_W'(1);
            cnt_nxt = '0;
            if (idx == IDX_W'(NUM_CH - 1)) state_nxt = RUN;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        RUN: begin
        end
        MAN_WAIT: begin
          rst_nxt = '1;
          if (!db_level) begin
            state_nxt = HOLD;
            cnt_nxt   = '0;
            idx_nxt   = '0;
          end
        end
        default: begin
          rst_nxt   = '1;
          state_nxt = HOLD;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end
      endcase
    end
  end

  // State, counters and all outputs update together on one edge.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= HOLD;
      cnt          <= '0;
      idx          <= '0;
      rst_out      <= '1;
      all_released <= 1'b0;
      busy         <= 1'b1;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      idx          <= idx_nxt;
      rst_out      <= rst_nxt;
      all_released <= (rst_nxt == '0);
      busy         <= (state_nxt != RUN);
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: default configuration plus a
// minimal single-channel configuration.
module tb_reset_sequencer;

  localparam int NUM_CH    = 3;
  localparam int HOLD      = 4;
  localparam int STAG      = 2;
  localparam int DEB       = 8;
  localparam int SYNC      = 2;
  localparam int PRESS_LAT = SYNC + DEB;

  logic              clk = 1'b0;
  logic              n_rst;
  logic              manual;
  logic              sw_req;
  logic [NUM_CH-1:0] rst_out;
  logic              all_released;
  logic              busy;

  logic              n_rst_min;
  logic              manual_min;
  logic              sw_req_min;
  logic [0:0]        rst_min;
  logic              all_min;
  logic              busy_min;

  typedef struct {
    int                k;
    logic [NUM_CH-1:0] rst;
    logic              all;
    logic              busy;
  } exp_t;

  exp_t       sb[$];
  logic [2:0] sb_min[$];
  int         vectors     = 0;
  int         miscompares = 0;

  always #5 clk = ~clk;

  reset_sequencer #(
    .NUM_CH(NUM_CH), .HOLD_CYCLES(HOLD), .STAGGER_CYCLES(STAG),
    .DEBOUNCE_CYCLES(DEB), .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk), .n_rst(n_rst), .manual(manual), .sw_req(sw_req),
    .rst_out(rst_out), .all_released(all_released), .busy(busy)
  );

  reset_sequencer #(
    .NUM_CH(1), .HOLD_CYCLES(1), .STAGGER_CYCLES(1),
    .DEBOUNCE_CYCLES(DEB), .SYNC_STAGES(SYNC)
  ) dut_min (
    .clk(clk), .n_rst(n_rst_min), .manual(manual_min), .sw_req(sw_req_min),
    .rst_out(rst_min), .all_released(all_min), .busy(busy_min)
  );

  // Expected outputs r edges after a sequence start (r < 0: still held).
  function automatic exp_t seq_exp(int k, int r);
    exp_t e;
    e.k = k;
    for (int i = 0; i < NUM_CH; i++) e.rst[i] = (r < HOLD + i * STAG);
    e.all  = (e.rst == '0);
    e.busy = !e.all;
    return e;
  endfunction

  task automatic test_reset();
    exp_t e;
    n_rst = 1'b0;
    n_rst_min = 1'b0;
    #1;
    sb.push_back(seq_exp(0, -1));
    sb.push_back(seq_exp(0, -1));
    for (int k = 0; k < 2; k++) begin
      if (k == 1) begin
        repeat (2) @(posedge clk);
        #1;
      end
      e = sb.pop_front();
      vectors++;
      if ({rst_out, all_released, busy} !== {e.rst, e.all, e.busy}) begin
        miscompares++;
        $display("FAIL reset k=%0d: got rst_out=%b all=%b busy=%b, expected %b %b %b",
                 k, rst_out, all_released, busy, e.rst, e.all, e.busy);
      end
    end
  endtask

  task automatic test_power_up();
    exp_t e;
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    for (int k = 1; k <= 12; k++) sb.push_back(seq_exp(k, k));
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      e = sb.pop_front();
      vectors++;
      if ({rst_out, all_released, busy} !== {e.rst, e.all, e.busy}) begin
        miscompares++;
        $display("FAIL power_up edge %0d: got rst_out=%b all=%b busy=%b, expected %b %b %b",
                 e.k, rst_out, all_released, busy, e.rst, e.all, e.busy);
      end
    end
  endtask

  // 5-cycle and (DEB-1)-cycle button glitches must both be ignored.
  task automatic test_glitch();
    exp_t e;
    for (int k = 1; k <= 40; k++) sb.push_back(seq_exp(k, 1000));
    for (int k = 1; k <= 40; k++) begin
      manual = (k <= 5) || (k >= 16 && k <= 16 + DEB - 2);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      vectors++;
      if ({rst_out, all_released, busy} !== {e.rst, e.all, e.busy}) begin
        miscompares++;
        $display("FAIL glitch edge %0d: got rst_out=%b all=%b busy=%b, expected %b %b %b",
                 e.k, rst_out, all_released, busy, e.rst, e.all, e.busy);
      end
    end
    manual = 1'b0;
  endtask

  task automatic test_manual_press();
    exp_t e;
    int   start;
    start = 31 + PRESS_LAT;
    for (int k = 1; k <= start + HOLD + 2 * STAG + 2; k++)
      sb.push_back((k < PRESS_LAT) ? seq_exp(k, 1000) : seq_exp(k, k - start));
    for (int k = 1; k <= start + HOLD + 2 * STAG + 2; k++) begin
      manual = (k <= 30);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      vectors++;
      if ({rst_out, all_released, busy} !== {e.rst, e.all, e.busy}) begin
        miscompares++;
        $display("FAIL manual_press edge %0d: got rst_out=%b all=%b busy=%b, expected %b %b %b",
                 e.k, rst_out, all_released, busy, e.rst, e.all, e.busy);
      end
    end
    manual = 1'b0;
  endtask

  // Restart from RUN, then again while in RELEASE with rst_out = 110.
  task automatic test_sw_req();
    exp_t e;
    for (int k = 1; k <= 16; k++)
      sb.push_back((k < 6) ? seq_exp(k, k - 1) : seq_exp(k, k - 6));
    for (int k = 1; k <= 16; k++) begin
      sw_req = (k == 1) || (k == 6);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      vectors++;
      if ({rst_out, all_released, busy} !== {e.rst, e.all, e.busy}) begin
        miscompares++;
        $display("FAIL sw_req edge %0d: got rst_out=%b all=%b busy=%b, expected %b %b %b",
                 e.k, rst_out, all_released, busy, e.rst, e.all, e.busy);
      end
    end
    sw_req = 1'b0;
  endtask

  // Second request during HOLD restarts the hold count.
  task automatic test_back_to_back();
    exp_t e;
    for (int k = 1; k <= 12; k++)
      sb.push_back((k < 3) ? seq_exp(k, k - 1) : seq_exp(k, k - 3));
    for (int k = 1; k <= 12; k++) begin
      sw_req = (k == 1) || (k == 3);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      vectors++;
      if ({rst_out, all_released, busy} !== {e.rst, e.all, e.busy}) begin
        miscompares++;
        $display("FAIL back_to_back edge %0d: got rst_out=%b all=%b busy=%b, expected %b %b %b",
                 e.k, rst_out, all_released, busy, e.rst, e.all, e.busy);
      end
    end
    sw_req = 1'b0;
  endtask

  // Debounced press and sw_req on the same edge, then sw_req ignored in MAN_WAIT.
  task automatic test_both_events();
    exp_t e;
    int   start;
    start = 25 + PRESS_LAT;
    for (int k = 1; k <= start + 10; k++)
      sb.push_back((k < PRESS_LAT) ? seq_exp(k, 1000) : seq_exp(k, k - start));
    for (int k = 1; k <= start + 10; k++) begin
      manual = (k <= 24);
      sw_req = (k == PRESS_LAT) || (k == 13) || (k == 17) || (k == 21);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      vectors++;
      if ({rst_out, all_released, busy} !== {e.rst, e.all, e.busy}) begin
        miscompares++;
        $display("FAIL both_events edge %0d: got rst_out=%b all=%b busy=%b, expected %b %b %b",
                 e.k, rst_out, all_released, busy, e.rst, e.all, e.busy);
      end
    end
    manual = 1'b0;
    sw_req = 1'b0;
  endtask

  // Reset asserted mid-RELEASE takes effect without a clock, then power-up repeats.
  task automatic test_async_reset();
    exp_t e;
    for (int k = 1; k <= 5; k++) sb.push_back(seq_exp(k, k - 1));
    for (int k = 1; k <= 5; k++) begin
      sw_req = (k == 1);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      vectors++;
      if ({rst_out, all_released, busy} !== {e.rst, e.all, e.busy}) begin
        miscompares++;
        $display("FAIL async_pre edge %0d: got rst_out=%b all=%b busy=%b, expected %b %b %b",
                 e.k, rst_out, all_released, busy, e.rst, e.all, e.busy);
      end
    end
    sw_req = 1'b0;
    #2;
    n_rst = 1'b0;
    #1;
    sb.push_back(seq_exp(0, -1));
    e = sb.pop_front();
    vectors++;
    if ({rst_out, all_released, busy} !== {e.rst, e.all, e.busy}) begin
      miscompares++;
      $display("FAIL async_assert: got rst_out=%b all=%b busy=%b, expected %b %b %b",
               rst_out, all_released, busy, e.rst, e.all, e.busy);
    end
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    for (int k = 1; k <= 12; k++) sb.push_back(seq_exp(k, k));
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      e = sb.pop_front();
      vectors++;
      if ({rst_out, all_released, busy} !== {e.rst, e.all, e.busy}) begin
        miscompares++;
        $display("FAIL async_restart edge %0d: got rst_out=%b all=%b busy=%b, expected %b %b %b",
                 e.k, rst_out, all_released, busy, e.rst, e.all, e.busy);
      end
    end
  endtask

  // Single channel, hold 1, stagger 1: released on the first edge.
  task automatic test_min_params();
    logic [2:0] m;
    sb_min.push_back(3'b101);
    sb_min.push_back(3'b010);
    sb_min.push_back(3'b101);
    sb_min.push_back(3'b010);
    for (int k = 0; k < 4; k++) begin
      if (k == 1) begin
        n_rst_min = 1'b1;
        @(posedge clk);
        #1;
      end else if (k == 2) begin
        sw_req_min = 1'b1;
        @(posedge clk);
        #1;
        sw_req_min = 1'b0;
      end else if (k == 3) begin
        @(posedge clk);
        #1;
      end
      m = sb_min.pop_front();
      vectors++;
      if ({rst_min, all_min, busy_min} !== m) begin
        miscompares++;
        $display("FAIL min_params step %0d: got rst_out=%b all=%b busy=%b, expected %b",
                 k, rst_min, all_min, busy_min, m);
      end
    end
  endtask

  initial begin
    n_rst      = 1'b1;
    n_rst_min  = 1'b1;
    manual     = 1'b0;
    sw_req     = 1'b0;
    manual_min = 1'b0;
    sw_req_min = 1'b0;
    #1;
    test_reset();
    test_power_up();
    test_glitch();
    test_manual_press();
    test_sw_req();
    test_back_to_back();
    test_both_events();
    test_async_reset();
    test_min_params();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, vectors=%0d", vectors);
    $fatal(1, "timeout");
  end

endmodule
